// File: rtl/bus_generator_n_arbiter_pkg.sv
// Shared definitions for the bus generator / round-robin arbiter.
//   ID_W          : width of the destination ID field at the top of a packet
//   BROADCAST_ID  : default destination ID meaning "everyone but the source"
//   lane_state_t  : per-lane FSM states
//   id_lsb()      : bit offset of the destination ID inside a packet
package bus_generator_n_arbiter_pkg;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      PUSH
   } lane_state_t;

   function automatic int id_lsb(input int pckg_sz);
      return pckg_sz - ID_W;
   endfunction

endpackage

// File: rtl/bus_generator_n_arbiter_bus_lane.sv
// One bus lane: round-robin arbiter plus IDLE/POP/PUSH transfer FSM.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pndng      : per-device "transmit FIFO non-empty"
//   d_pop      : per-device FIFO head (first-word-fall-through)
//   pop        : registered one-cycle pop pulse to the granted device
//   push       : registered one-cycle delivery strobe(s)
//   d_push     : lane bus register fanned out to every device
module bus_generator_n_arbiter_bus_lane
   import bus_generator_n_arbiter_pkg::*;
#(
   parameter int drvrs = 4,
   parameter int pckg_sz = 16,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [drvrs-1:0]                 pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop,
   output logic [drvrs-1:0]                 pop,
   output logic [drvrs-1:0]                 push,
   output logic [drvrs-1:0][pckg_sz-1:0]    d_push
);

   localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam int ID_LSB = id_lsb(pckg_sz);

   lane_state_t        state_reg, state_next;
   logic [PW-1:0]      grant_reg, grant_next;
   logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
   logic [pckg_sz-1:0] pkt_reg, pkt_next;
   logic [pckg_sz-1:0] bus_reg, bus_next;
   logic [drvrs-1:0]   pop_reg, pop_next;
   logic [drvrs-1:0]   push_reg, push_next;
   logic [PW-1:0]      arb_grant;
   logic [ID_W-1:0]    dest_id;

   // First pending device at or after rr_ptr, wrapping modulo drvrs.
   // Walking offsets from high to low lets the smallest offset win last.
   always_comb begin
      int idx;
      arb_grant = '0;
      idx = 0;
      for (int i = drvrs - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= drvrs) idx = idx - drvrs;
         if (pndng[idx]) arb_grant = PW'(idx);
      end
   end

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_ptr_next = rr_ptr_reg;
      pkt_next    = pkt_reg;
      bus_next    = bus_reg;
      pop_next    = '0;
      push_next   = '0;
      dest_id     = pkt_reg[ID_LSB +: ID_W];
      case (state_reg)
         IDLE: begin
            if (|pndng) begin
               grant_next = arb_grant;
               for (int d = 0; d < drvrs; d++) pop_next[d] = (arb_grant == PW'(d));
               state_next = POP;
            end
         end
         POP: begin
            // Latch the head and decode it now so push lands in the PUSH cycle.
            pkt_next = d_pop[grant_reg];
            bus_next = pkt_next;
            dest_id  = pkt_next[ID_LSB +: ID_W];
            for (int d = 0; d < drvrs; d++) begin
               if (dest_id == broadcast) push_next[d] = (grant_reg != PW'(d));
               else                      push_next[d] = (dest_id == ID_W'(d));
            end
            state_next = PUSH;
         end
         PUSH: begin
            rr_ptr_next = (grant_reg == PW'(drvrs - 1)) ? '0 : grant_reg + PW'(1);
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
         pkt_reg    <= '0;
         bus_reg    <= '0;
         pop_reg    <= '0;
         push_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
         pkt_reg    <= pkt_next;
         bus_reg    <= bus_next;
         pop_reg    <= pop_next;
         push_reg   <= push_next;
      end
   end

   assign pop  = pop_reg;
   assign push = push_reg;

   genvar gi;
   generate
      for (gi = 0; gi < drvrs; gi++) begin : g_dpush
         assign d_push[gi] = bus_reg;
      end
   endgenerate

endmodule

// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator and round-robin arbiter: `bits` independent lanes,
// each connecting `drvrs` devices.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pndng      : [lane][device] transmit FIFO non-empty
//   D_pop      : [lane][device] transmit FIFO head
//   pop        : [lane][device] pop pulse
//   push       : [lane][device] delivery strobe
//   D_push     : [lane][device] delivered packet (qualified by push)
module bus_generator_n_arbiter
   import bus_generator_n_arbiter_pkg::*;
#(
   parameter int bits = 1,
   parameter int drvrs = 4,
   parameter int pckg_sz = 16,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [bits-1:0][drvrs-1:0]               pndng,
   input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
   output logic [bits-1:0][drvrs-1:0]               pop,
   output logic [bits-1:0][drvrs-1:0]               push,
   output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

   genvar gi;
   generate
      for (gi = 0; gi < bits; gi++) begin : g_lane
         bus_generator_n_arbiter_bus_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
         ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[gi]),
            .d_pop  (D_pop[gi]),
            .pop    (pop[gi]),
            .push   (push[gi]),
            .d_push (D_push[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
// Directed bench for bus_generator_n_arbiter (drvrs=6, pckg_sz=16, bits=1).
module tb_bus_generator_n_arbiter;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [0:0][5:0]        pndng;
   logic [0:0][5:0][15:0]  D_pop;
   logic [0:0][5:0]        pop;
   logic [0:0][5:0]        push;
   logic [0:0][5:0][15:0]  D_push;

   int pass_cnt = 0;
   int total_cnt = 0;

   bus_generator_n_arbiter #(
      .bits      (1),
      .drvrs     (6),
      .pckg_sz   (16),
      .broadcast (8'hFF)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (D_pop),
      .pop    (pop),
      .push   (push),
      .D_push (D_push)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      pndng = '0;
      D_pop = '0;
      tick;
      tick;
      total_cnt++;
      if ({pop, push} !== 12'h000) $display("FAIL reset_strobes: got %h required 000", {pop, push});
      else pass_cnt++;
      total_cnt++;
      if (D_push !== '0) $display("FAIL reset_dpush: got %h required 0", D_push);
      else pass_cnt++;
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         total_cnt++;
         if ({pop, push} !== 12'h000 || D_push !== '0)
            $display("FAIL idle_quiet cycle %0d: pop/push %h dpush %h required 0", c, {pop, push}, D_push);
         else pass_cnt++;
      end
      $display("test_reset done");
   endtask

   task automatic test_unicast;
      D_pop[0][1] = 16'h03AB;
      pndng[0] = 6'b000010;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b000010) $display("FAIL unicast_pop: got %b required 000010", pop[0]);
      else pass_cnt++;
      total_cnt++;
      if (push[0] !== 6'b000000) $display("FAIL unicast_early_push: got %b required 000000", push[0]);
      else pass_cnt++;
      tick;
      pndng[0] = '0;
      total_cnt++;
      if (pop[0] !== 6'b000000) $display("FAIL unicast_pop_len: got %b required 000000", pop[0]);
      else pass_cnt++;
      total_cnt++;
      if (push[0] !== 6'b001000) $display("FAIL unicast_push: got %b required 001000", push[0]);
      else pass_cnt++;
      total_cnt++;
      if (D_push[0][3] !== 16'h03AB || D_push[0][5] !== 16'h03AB)
         $display("FAIL unicast_data: got %h/%h required 03ab", D_push[0][3], D_push[0][5]);
      else pass_cnt++;
      tick;
      total_cnt++;
      if (push[0] !== 6'b000000) $display("FAIL unicast_push_len: got %b required 000000", push[0]);
      else pass_cnt++;
      $display("test_unicast done");
   endtask

   task automatic test_broadcast;
      D_pop[0][2] = 16'hFF55;
      pndng[0] = 6'b000100;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b000100) $display("FAIL bcast_pop: got %b required 000100", pop[0]);
      else pass_cnt++;
      tick;
      pndng[0] = '0;
      total_cnt++;
      if (push[0] !== 6'b111011) $display("FAIL bcast_push: got %b required 111011", push[0]);
      else pass_cnt++;
      total_cnt++;
      if (D_push[0][0] !== 16'hFF55) $display("FAIL bcast_data: got %h required ff55", D_push[0][0]);
      else pass_cnt++;
      tick;
      total_cnt++;
      if (push[0] !== 6'b000000) $display("FAIL bcast_push_len: got %b required 000000", push[0]);
      else pass_cnt++;
      $display("test_broadcast done");
   endtask

   // All six devices pending with destination 0; device 0 holds a second packet.
   task automatic test_round_robin;
      int          dev_seq[7] = '{0, 1, 2, 3, 4, 5, 0};
      logic [15:0] data_seq[7] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                   16'h0004, 16'h0005, 16'h0042};
      int n = 0;
      int cyc = 0;
      int last_cyc = 0;
      int due_idx = 0;
      int clr_dev = -1;
      bit push_due = 1'b0;
      bit reloaded = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int d = 0; d < 6; d++) D_pop[0][d] = data_seq[d];
      pndng[0] = 6'h3F;
      while (n < 7 && cyc < 60) begin
         tick;
         cyc++;
         if (push_due) begin
            total_cnt++;
            if (push[0] !== 6'b000001 || D_push[0][0] !== data_seq[due_idx])
               $display("FAIL rr_push %0d: got %b/%h required 000001/%h", due_idx, push[0], D_push[0][0], data_seq[due_idx]);
            else pass_cnt++;
            push_due = 1'b0;
         end
         if (clr_dev >= 0) begin
            if (clr_dev == 0 && !reloaded) begin
               D_pop[0][0] = 16'h0042;
               reloaded = 1'b1;
            end else begin
               pndng[0][clr_dev] = 1'b0;
            end
            clr_dev = -1;
         end
         if (pop[0] !== 6'b000000) begin
            total_cnt++;
            if (pop[0] !== 6'(1 << dev_seq[n]))
               $display("FAIL rr_grant %0d: got %b required device %0d", n, pop[0], dev_seq[n]);
            else pass_cnt++;
            if (n > 0) begin
               total_cnt++;
               if (cyc - last_cyc != 3)
                  $display("FAIL rr_spacing %0d: got %0d cycles required 3", n, cyc - last_cyc);
               else pass_cnt++;
            end
            last_cyc = cyc;
            push_due = 1'b1;
            due_idx = n;
            clr_dev = dev_seq[n];
            n++;
         end
      end
      if (n < 7) begin
         total_cnt++;
         $display("FAIL rr_timeout: got %0d grants required 7", n);
      end
      tick;
      total_cnt++;
      if (push[0] !== 6'b000001 || D_push[0][0] !== 16'h0042)
         $display("FAIL rr_last_push: got %b/%h required 000001/0042", push[0], D_push[0][0]);
      else pass_cnt++;
      pndng[0] = '0;
      tick;
      $display("test_round_robin done");
   endtask

   task automatic test_invalid_id;
      D_pop[0][4] = 16'h0911;
      pndng[0] = 6'b010000;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b010000) $display("FAIL inval_pop: got %b required 010000", pop[0]);
      else pass_cnt++;
      tick;
      pndng[0] = '0;
      total_cnt++;
      if (push[0] !== 6'b000000) $display("FAIL inval_push: got %b required 000000", push[0]);
      else pass_cnt++;
      tick;
      // Pointer should now sit at 5: device 5 wins over device 0.
      D_pop[0][0] = 16'h0100;
      D_pop[0][5] = 16'h0200;
      pndng[0] = 6'b100001;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b100000) $display("FAIL inval_rr_next: got %b required 100000", pop[0]);
      else pass_cnt++;
      tick;
      pndng[0][5] = 1'b0;
      total_cnt++;
      if (push[0] !== 6'b000100 || D_push[0][2] !== 16'h0200)
         $display("FAIL inval_next_push: got %b/%h required 000100/0200", push[0], D_push[0][2]);
      else pass_cnt++;
      tick;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b000001) $display("FAIL wrap_grant: got %b required 000001", pop[0]);
      else pass_cnt++;
      tick;
      pndng[0] = '0;
      total_cnt++;
      if (push[0] !== 6'b000010 || D_push[0][1] !== 16'h0100)
         $display("FAIL wrap_push: got %b/%h required 000010/0100", push[0], D_push[0][1]);
      else pass_cnt++;
      tick;
      $display("test_invalid_id done");
   endtask

   // Reset lands on the edge that would load the push for a popped packet.
   task automatic test_reset_mid;
      D_pop[0][2] = 16'h0277;
      pndng[0] = 6'b000100;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b000100) $display("FAIL mid_pop: got %b required 000100", pop[0]);
      else pass_cnt++;
      reset = 1'b1;
      pndng[0] = '0;
      tick;
      total_cnt++;
      if ({pop, push} !== 12'h000 || D_push !== '0)
         $display("FAIL mid_reset_out: pop/push %h dpush %h required 0", {pop, push}, D_push);
      else pass_cnt++;
      reset = 1'b0;
      D_pop[0][0] = 16'h0455;
      D_pop[0][3] = 16'h0133;
      pndng[0] = 6'b001001;
      tick;
      total_cnt++;
      if (pop[0] !== 6'b000001) $display("FAIL mid_restart: got %b required 000001", pop[0]);
      else pass_cnt++;
      tick;
      pndng[0] = '0;
      total_cnt++;
      if (push[0] !== 6'b010000 || D_push[0][4] !== 16'h0455)
         $display("FAIL mid_restart_push: got %b/%h required 010000/0455", push[0], D_push[0][4]);
      else pass_cnt++;
      tick;
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset;
      test_unicast;
      test_broadcast;
      test_round_robin;
      test_invalid_id;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
